// File: rtl/flex_strobe_counter.sv
// flex_strobe_counter
// Strobe-qualified up/down counter with a programmable terminal value.
// It supports wrap or one-shot behaviour, halt (bit-stuff freeze), clear and load.
// All outputs are registered. rollover_flag is computed from the next count,
// so it lines up with count_out with no extra latency.

module flex_strobe_counter #(
    parameter int NUM_CNT_BITS = 4,
    parameter int START_VALUE  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    strobe,
    input  logic                    count_enable,
    input  logic                    halt,
    input  logic                    clear,
    input  logic                    load,
    input  logic [NUM_CNT_BITS-1:0] load_value,
    input  logic [NUM_CNT_BITS-1:0] rollover_value,
    input  logic                    count_down,
    input  logic                    one_shot,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    rollover_flag,
    output logic                    rollover_pulse,
    output logic                    done
);

    localparam logic [NUM_CNT_BITS-1:0] START_C = NUM_CNT_BITS'(START_VALUE);
    localparam logic [NUM_CNT_BITS-1:0] ONE_C   = NUM_CNT_BITS'(1);

    // Flag rule shared by reset and normal operation.
    // A degenerate range (rollover_value <= START_VALUE) pins the count at
    // START_VALUE, and that pinned value reads as terminal.
    function automatic logic flag_of(
        input logic [NUM_CNT_BITS-1:0] cnt,
        input logic [NUM_CNT_BITS-1:0] term,
        input logic                    degen
    );
        return (cnt == term) || (degen && (cnt == START_C));
    endfunction

    logic [NUM_CNT_BITS-1:0] count_r;
    logic                    flag_r;
    logic                    pulse_r;
    logic                    done_r;

    logic                    tick_s;
    logic [NUM_CNT_BITS-1:0] terminal_s;
    logic [NUM_CNT_BITS-1:0] wrap_s;
    logic                    at_term_s;
    logic                    degen_s;
    logic [NUM_CNT_BITS-1:0] next_count_s;
    logic                    next_flag_s;
    logic                    next_pulse_s;
    logic                    next_done_s;
    logic                    freeze_s;

    // Decode direction: terminal end, wrap end, and whether the count sits at or past terminal.
    always_comb begin
        tick_s  = strobe & count_enable & ~halt;
        degen_s = (rollover_value <= START_C);
        if (count_down) begin
            terminal_s = START_C;
            wrap_s     = rollover_value;
            at_term_s  = (count_r <= START_C);
        end else begin
            terminal_s = rollover_value;
            wrap_s     = START_C;
            at_term_s  = (count_r >= rollover_value);
        end
    end

    // Next-state selection with priority clear > load > halt > tick > hold.
    always_comb begin
        next_count_s = count_r;
        next_done_s  = done_r;
        next_pulse_s = 1'b0;
        freeze_s     = 1'b0;
        if (clear) begin
            next_count_s = START_C;
            next_done_s  = 1'b0;
        end else if (load) begin
            next_count_s = load_value;
            next_done_s  = 1'b0;
        end else if (halt) begin
            freeze_s = 1'b1;
        end else if (tick_s) begin
            if (degen_s) begin
                next_count_s = START_C;
            end else if (at_term_s) begin
                if (one_shot) begin
                    next_done_s = 1'b1;
                end else begin
                    next_count_s = wrap_s;
                    next_pulse_s = 1'b1;
                end
            end else if (count_down) begin
                next_count_s = count_r - ONE_C;
            end else begin
                next_count_s = count_r + ONE_C;
            end
        end else begin
            next_count_s = count_r;
        end
    end

    // While halted the flag freezes; otherwise it tracks the next count and live terminal.
    always_comb begin
        next_flag_s = 1'b0;
        if (freeze_s) begin
            next_flag_s = flag_r;
        end else begin
            next_flag_s = flag_of(next_count_s, terminal_s, degen_s);
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= START_C;
            flag_r  <= flag_of(START_C, terminal_s, degen_s);
            pulse_r <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            count_r <= next_count_s;
            flag_r  <= next_flag_s;
            pulse_r <= next_pulse_s;
            done_r  <= next_done_s;
        end
    end

    assign count_out      = count_r;
    assign rollover_flag  = flag_r;
    assign rollover_pulse = pulse_r;
    assign done           = done_r;

endmodule

// File: doc/flex_strobe_counter.md
FLEX_STROBE_COUNTER -- requirements
Module: flex_strobe_counter

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 Parameter NUM_CNT_BITS, default 4, SHALL set the counter width; legal range 2..16.
REQ-003 Parameter START_VALUE, default 1, SHALL set the count reached on reset, clear and wrap; legal range 0..2^NUM_CNT_BITS-1.
REQ-004 Port clk, input, 1, SHALL be the system clock; all state SHALL change on its rising edge only.
REQ-005 Port rst, input, 1, SHALL be the synchronous active-high reset.
REQ-006 Port strobe, input, 1, SHALL be the bit-rate enable pulse (12 MHz tick, one clk wide).
REQ-007 Port count_enable, input, 1, SHALL permit counting on a strobe.
REQ-008 Port halt, input, 1, SHALL freeze the count (bit-stuff insertion) while high.
REQ-009 Port clear, input, 1, SHALL return the count to START_VALUE.
REQ-010 Port load, input, 1, SHALL load load_value into the count.
REQ-011 Port load_value, input, NUM_CNT_BITS, SHALL be the value taken on load.
REQ-012 Port rollover_value, input, NUM_CNT_BITS, SHALL be the terminal count.
REQ-013 Port count_down, input, 1, SHALL select direction: 0 counts up START_VALUE->rollover_value, 1 counts down rollover_value->START_VALUE.
REQ-014 Port one_shot, input, 1, SHALL select mode: 0 wraps at terminal, 1 stops at terminal.
REQ-015 Port count_out, output, NUM_CNT_BITS, SHALL be the registered count.
REQ-016 Port rollover_flag, output, 1, SHALL be high, registered, while count_out equals the terminal value.
REQ-017 Port rollover_pulse, output, 1, SHALL pulse high for one clk on each wrap.
REQ-018 Port done, output, 1, SHALL be high, sticky, once one_shot mode reaches terminal.

Function
REQ-019 The block SHALL define tick = strobe & count_enable & ~halt.
REQ-020 The block SHALL apply priority per clk: rst > clear > load > halt > tick > hold.
REQ-021 clear and load SHALL act on any clk edge, independent of strobe.
REQ-022 clear SHALL set count_out=START_VALUE and done=0.
REQ-023 load SHALL set count_out=load_value and done=0.
REQ-024 Terminal SHALL be rollover_value when counting up and START_VALUE when counting down; the wrap target SHALL be the opposite end.
REQ-025 On a tick in up mode, a count below terminal SHALL increment by 1; a count at or above terminal SHALL go to the wrap target (REQ-029).
REQ-026 On a tick in down mode, a count above START_VALUE SHALL decrement by 1; a count at or below START_VALUE SHALL go to the wrap target (REQ-029).
REQ-027 When rollover_value <= START_VALUE, count_out SHALL be held at START_VALUE on ticks, with rollover_flag=1 and no rollover_pulse.
REQ-028 Arithmetic SHALL be NUM_CNT_BITS wide and never wrap modulo 2^N; the terminal compare SHALL bound it.
REQ-029 On a terminal tick with one_shot=0: count_out SHALL go to the wrap target and rollover_pulse=1 in the same cycle the wrapped count appears.
REQ-030 On a terminal tick with one_shot=1: count_out SHALL hold, done SHALL set to 1, and rollover_pulse SHALL stay 0.
REQ-031 rollover_flag SHALL be computed from the next count and registered, giving zero added latency against count_out.
REQ-032 A change of rollover_value or count_down SHALL take effect on the next edge, and rollover_flag SHALL re-evaluate that edge.
REQ-033 halt SHALL hold count_out, rollover_flag and done; rollover_pulse SHALL be 0 while halt is high.
REQ-034 Simultaneous clear and tick SHALL give count_out=START_VALUE with no rollover_pulse.
REQ-035 Simultaneous load and tick SHALL give count_out=load_value, ignoring the tick.
REQ-036 The count SHALL change at most once per strobe; strobe low SHALL mean hold.

Reset
REQ-037 While rst is high at a clk edge: count_out=START_VALUE, rollover_flag=(START_VALUE==terminal at that edge), rollover_pulse=0, done=0.
REQ-038 rst SHALL override all inputs, including mid-count and mid-halt.
REQ-039 Counting SHALL resume on the first tick after rst deasserts.

Verification
REQ-040 N=4, START=1, rollover=8, up, wrap, strobe every 4 clk -> count 1..8; flag high at 8; next tick gives 1 with a 1-clk pulse.
REQ-041 Same setup, halt high for 2 strobes at count 5 -> count stays 5, no pulse, then resumes 6.
REQ-042 one_shot=1, rollover=3 -> count 1,2,3 then holds 3, done=1 sticky; clear -> count 1, done=0.
REQ-043 count_down=1, rollover=5, START=1, load_value=5 loaded -> 5,4,3,2,1, flag at 1, wrap to 5 with pulse.
REQ-044 Count 7, rollover changed to 4, tick -> count 1 with pulse (above-terminal wrap); clear+tick same cycle -> count 1, no pulse.
REQ-045 rst pulsed mid-count at 6 -> count 1, outputs 0 next edge; first tick after release gives 2.
